// File: rtl/dlx_mac_pkg.sv
// Shared state encodings and default parameters for the DLX memory-access
// burst controller.
package dlx_mac_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT4ACK = 2'd1,
    NEXT     = 2'd2,
    ERR      = 2'd3
  } mac_state_t;

  localparam int unsigned DEF_BURST_W     = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 15;
  localparam int unsigned DEF_WAIT_W      = 4;

endpackage

// File: rtl/dlx_mac_burst_fsm_if.sv
// CPU request/stall and external bus handshake bundle for dlx_mac_burst_fsm.
// master = the controller, slave = the CPU/bus environment around it.
interface dlx_mac_burst_fsm_if #(
  parameter int unsigned BURST_W = 2
);
  logic               MR;
  logic               MW;
  logic [BURST_W-1:0] BURST_LEN;
  logic               ACK_N;
  logic               busy;
  logic               AS_N;
  logic               WR_N;
  logic               STOP_N;
  logic [BURST_W-1:0] BEAT;
  logic               LAST;
  logic               TIMEOUT_ERR;
  logic [1:0]         STATE;

  modport master (
    input  MR, MW, BURST_LEN, ACK_N,
    output busy, AS_N, WR_N, STOP_N, BEAT, LAST, TIMEOUT_ERR, STATE
  );

  modport slave (
    output MR, MW, BURST_LEN, ACK_N,
    input  busy, AS_N, WR_N, STOP_N, BEAT, LAST, TIMEOUT_ERR, STATE
  );
endinterface

// File: rtl/mac_wait_timer.sv
// Per-beat wait-state counter: clear has priority, counts while enabled,
// saturates at all-ones and flags when the timeout limit is reached.
module mac_wait_timer #(
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic waited,
  output logic expired
);

  logic [WAIT_W-1:0] wait_cnt;

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYC);
      assign expired = (wait_cnt == LIMIT);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (en && !expired && (wait_cnt != {WAIT_W{1'b1}})) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign waited = (wait_cnt != '0);

endmodule

// File: rtl/dlx_mac_burst_fsm.sv
// DLX memory-access controller: runs single or multi-beat bus bursts with
// AS_N/WR_N/ACK_N/STOP_N handshake and a per-beat wait-state timeout.
module dlx_mac_burst_fsm
  import dlx_mac_pkg::*;
#(
  parameter int unsigned BURST_W     = DEF_BURST_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned WAIT_W      = DEF_WAIT_W
) (
  input logic                 CLK,
  input logic                 RESET,
  dlx_mac_burst_fsm_if.master bus
);

  mac_state_t         state;
  logic [BURST_W-1:0] beat;
  logic [BURST_W-1:0] len;
  logic               is_wr;

  logic req;
  logic in_wait;
  logic at_last;
  logic acked;
  logic waited;
  logic expired;
  logic timer_clr;
  logic timer_en;

  assign req     = bus.MR | bus.MW;
  assign in_wait = (state == WAIT4ACK);
  assign at_last = (beat == len);
  assign acked   = in_wait && !bus.ACK_N;

  // A new beat (or a new request) restarts the wait count.
  assign timer_clr = ((state == IDLE) && req) || (acked && !at_last);
  assign timer_en  = in_wait && bus.ACK_N;

  mac_wait_timer #(
    .WAIT_W     (WAIT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (CLK),
    .srst   (RESET),
    .clr    (timer_clr),
    .en     (timer_en),
    .waited (waited),
    .expired(expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      beat  <= '0;
      len   <= '0;
      is_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            len   <= bus.BURST_LEN;
            is_wr <= bus.MW;
            beat  <= '0;
            state <= WAIT4ACK;
          end
        end
        WAIT4ACK: begin
          // An acknowledge always beats a coincident timeout.
          if (!bus.ACK_N) begin
            if (!at_last) begin
              beat <= beat + BURST_W'(1);
            end else begin
              state <= NEXT;
            end
          end else if (expired) begin
            state <= ERR;
          end
        end
        NEXT:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.AS_N        = !in_wait;
  assign bus.WR_N        = !(in_wait && is_wr);
  assign bus.STOP_N      = !(in_wait && bus.ACK_N && waited);
  assign bus.BEAT        = beat;
  assign bus.LAST        = in_wait && at_last;
  assign bus.TIMEOUT_ERR = (state == ERR);
  assign bus.STATE       = state;
  assign bus.busy        = req && !RESET &&
                           ((state == IDLE) || (in_wait && !(acked && at_last)));

endmodule

// File: tb/tb_dlx_mac_burst_fsm.sv
// Randomised bench for dlx_mac_burst_fsm: a transaction-level model expands
// each burst into an expected per-cycle timeline that is replayed and compared.
module tb_dlx_mac_burst_fsm;

  localparam int TCYC = 15;

  typedef struct packed {
    logic       busy;
    logic       as_n;
    logic       wr_n;
    logic       stop_n;
    logic [1:0] beat;
    logic       last;
    logic       terr;
    logic [1:0] state;
  } out_t;

  typedef struct {
    logic       rst;
    logic       mr;
    logic       mw;
    logic [1:0] blen;
    logic       ack_n;
    out_t       exp;
  } rec_t;

  logic CLK;
  logic RESET;
  dlx_mac_burst_fsm_if #(.BURST_W(2)) bus ();

  dlx_mac_burst_fsm #(
    .BURST_W    (2),
    .TIMEOUT_CYC(TCYC),
    .WAIT_W     (4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   vectors;
  int   miscompares;
  rec_t q[$];
  logic [1:0] prev_beat;

  function automatic out_t mk(input logic busy, input logic as_n, input logic wr_n,
                              input logic stop_n, input logic [1:0] beat,
                              input logic last, input logic terr, input logic [1:0] st);
    out_t o;
    o.busy = busy; o.as_n = as_n; o.wr_n = wr_n; o.stop_n = stop_n;
    o.beat = beat; o.last = last; o.terr = terr; o.state = st;
    return o;
  endfunction

  function automatic out_t obs();
    return {bus.busy, bus.AS_N, bus.WR_N, bus.STOP_N, bus.BEAT,
            bus.LAST, bus.TIMEOUT_ERR, bus.STATE};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Idle cycles with no request: controller sits in IDLE, beat keeps its value.
  task automatic gen_idle(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r.rst = 1'b0; r.mr = 1'b0; r.mw = 1'b0;
      r.blen = 2'($urandom); r.ack_n = rbit();
      r.exp = mk(1'b0, 1'b1, 1'b1, 1'b1, prev_beat, 1'b0, 1'b0, 2'd0);
      q.push_back(r);
    end
  endtask

  // One burst: dly[b] = number of ACK_N-high cycles before beat b is acked.
  task automatic gen_txn(input logic mr, input logic mw, input int len, input int dly[4]);
    rec_t r;
    logic wr;
    logic acked;
    wr = mw;
    r.rst = 1'b0; r.mr = mr; r.mw = mw; r.blen = 2'(len); r.ack_n = rbit();
    r.exp = mk(1'b1, 1'b1, 1'b1, 1'b1, prev_beat, 1'b0, 1'b0, 2'd0);
    q.push_back(r);
    for (int b = 0; b <= len; b++) begin
      for (int w = 0; ; w++) begin
        acked = (w >= dly[b]);
        r.mr = mr; r.mw = mw; r.blen = 2'($urandom); r.ack_n = !acked;
        r.exp = mk(!(acked && b == len), 1'b0, !wr,
                   acked ? 1'b1 : !(w >= 1), 2'(b), (b == len), 1'b0, 2'd1);
        q.push_back(r);
        if (acked) break;
        if (TCYC != 0 && w == TCYC) begin
          r.mr = rbit(); r.mw = rbit(); r.blen = 2'($urandom); r.ack_n = rbit();
          r.exp = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'(b), 1'b0, 1'b1, 2'd3);
          q.push_back(r);
          prev_beat = 2'(b);
          return;
        end
      end
    end
    // NEXT: any request level here is ignored.
    r.mr = rbit(); r.mw = rbit(); r.blen = 2'($urandom); r.ack_n = rbit();
    r.exp = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'(len), 1'b0, 1'b0, 2'd2);
    q.push_back(r);
    prev_beat = 2'(len);
  endtask

  task automatic apply(input rec_t r);
    @(negedge CLK);
    RESET = r.rst; bus.MR = r.mr; bus.MW = r.mw;
    bus.BURST_LEN = r.blen; bus.ACK_N = r.ack_n;
    #2;
  endtask

  task automatic test_reset();
    rec_t r;
    int n;
    for (int i = 0; i < 3; i++) begin
      r.rst = 1'b1; r.mr = rbit(); r.mw = 1'b1; r.blen = 2'($urandom); r.ack_n = rbit();
      r.exp = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
      q.push_back(r);
    end
    prev_beat = 2'd0;
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL reset cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_single_read();
    rec_t r;
    int n;
    int d[4] = '{0, 0, 0, 0};
    gen_txn(1'b1, 1'b0, 0, d);
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL single_read cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_write_waits();
    rec_t r;
    int n;
    int d[4] = '{3, 0, 0, 0};
    gen_txn(1'b0, 1'b1, 0, d);
    gen_idle(1);
    d = '{1, 2, 0, 0};
    gen_txn(1'b1, 1'b1, 1, d);
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL write_waits cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_burst4();
    rec_t r;
    int n;
    int d[4] = '{0, 0, 0, 0};
    gen_txn(1'b1, 1'b0, 3, d);
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL burst4 cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_timeout();
    rec_t r;
    int n;
    int d[4] = '{40, 0, 0, 0};
    gen_txn(1'b0, 1'b1, 0, d);
    gen_idle(2);
    d = '{0, 25, 0, 0};
    gen_txn(1'b1, 1'b0, 2, d);
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL timeout cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_ack_at_limit();
    rec_t r;
    int n;
    int d[4] = '{TCYC, TCYC, 0, 0};
    gen_txn(1'b0, 1'b1, 1, d);
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL ack_at_limit cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    rec_t r;
    int n;
    int d[4] = '{0, 0, 0, 0};
    gen_txn(1'b1, 1'b0, 3, d);
    // Keep request, beat0, beat1; assert reset during the beat-2 cycle.
    while (q.size() > 4) r = q.pop_back();
    r = q.pop_back();
    r.rst = 1'b1;
    r.exp.busy = 1'b0;
    q.push_back(r);
    for (int i = 0; i < 2; i++) begin
      r.rst = 1'b1; r.mr = 1'b1; r.mw = 1'b0; r.blen = 2'($urandom); r.ack_n = rbit();
      r.exp = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
      q.push_back(r);
    end
    prev_beat = 2'd0;
    gen_idle(2);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL reset_mid_burst cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    int n;
    int d[4];
    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < 4; b++) d[b] = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       gen_txn(1'b1, 1'b0, $urandom_range(0, 3), d);
        1:       gen_txn(1'b0, 1'b1, $urandom_range(0, 3), d);
        default: gen_txn(1'b1, 1'b1, $urandom_range(0, 3), d);
      endcase
    end
    gen_idle(1);
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  task automatic test_random();
    rec_t r;
    int n;
    int d[4];
    for (int t = 0; t < 40; t++) begin
      for (int b = 0; b < 4; b++)
        d[b] = ($urandom_range(0, 9) == 0) ? $urandom_range(TCYC - 1, TCYC + 3)
                                           : $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       gen_txn(1'b1, 1'b0, $urandom_range(0, 3), d);
        1:       gen_txn(1'b0, 1'b1, $urandom_range(0, 3), d);
        default: gen_txn(1'b1, 1'b1, $urandom_range(0, 3), d);
      endcase
      gen_idle($urandom_range(0, 2));
    end
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front(); apply(r); vectors++; n++;
      if (obs() !== r.exp) begin
        miscompares++;
        $display("FAIL random cyc%0d got=%b want=%b", n, obs(), r.exp);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    prev_beat = 2'd0;
    RESET = 1'b1;
    bus.MR = 1'b0; bus.MW = 1'b0; bus.BURST_LEN = 2'd0; bus.ACK_N = 1'b1;
    test_reset();
    test_single_read();
    test_write_waits();
    test_burst4();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
